// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends a shared up counter to one requester at a time.
// Optional COUNTER_ARB_PRESCALE_EN slows count steps to one per PRESCALE clocks.
module counter_arbiter #(
  parameter int WIDTH    = 4,
  parameter int NREQ     = 2,
  parameter int PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] limit,
  output logic [NREQ-1:0]       grant,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic [NREQ-1:0]       done
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [PTRW-1:0]  r_ptr;
  logic [PTRW-1:0]  r_own;
  logic [WIDTH-1:0] r_lim;
  logic [WIDTH-1:0] r_cnt;
  logic [NREQ-1:0]  r_grant;
  logic [NREQ-1:0]  r_done;
  logic             r_busy;

  logic             w_any;
  logic [PTRW-1:0]  w_win;
  logic [PTRW-1:0]  w_idx;
  logic [PTRW-1:0]  w_next;
  logic             w_step;
  int               w_sum;

  // Scan downward so the lowest offset from the pointer wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_sum = 0;
    w_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_sum = int'(r_ptr) + i;
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      w_idx = PTRW'(w_sum);
      if (req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_next = (r_own == PTRW'(NREQ - 1)) ? '0 : r_own + 1'b1;

`ifdef COUNTER_ARB_PRESCALE_EN
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PSW-1:0] r_pre;

  assign w_step = (r_pre == PSW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
    end else if (r_state != S_COUNT || !req[r_own] || w_step) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end
`else
  logic w_unused_pre;

  assign w_step       = 1'b1;
  assign w_unused_pre = (PRESCALE > 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_own   <= '0;
      r_lim   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= NREQ'(1) << w_win;
            r_own   <= w_win;
            r_lim   <= limit[int'(w_win)*WIDTH +: WIDTH];
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (!req[r_own]) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_ptr   <= w_next;
            r_state <= S_IDLE;
          end else if (w_step) begin
            if (r_cnt == r_lim) begin
              r_done  <= r_grant;
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_ptr   <= w_next;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant = r_grant;
  assign count = r_cnt;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with NREQ=2, WIDTH=4.
// Cycle table plus hand sequences for reset, withdrawal and limit extremes.
module tb_counter_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [7:0] limit;
  logic [1:0] grant;
  logic [3:0] count;
  logic       busy;
  logic [1:0] done;

  int total;
  int bad;

  counter_arbiter #(
    .WIDTH   (4),
    .NREQ    (2),
    .PRESCALE(4)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .req  (req),
    .limit(limit),
    .grant(grant),
    .count(count),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] r;
    logic [3:0] l0;
    logic [3:0] l1;
    logic [1:0] g;
    logic [3:0] c;
    logic       b;
    logic [1:0] d;
  } vec_t;

  vec_t tv [33];

  function automatic vec_t mk(logic [1:0] r, logic [3:0] l0,
                              logic [3:0] l1, logic [1:0] g,
                              logic [3:0] c, logic b, logic [1:0] d);
    vec_t v;
    v.r  = r;
    v.l0 = l0;
    v.l1 = l1;
    v.g  = g;
    v.c  = c;
    v.b  = b;
    v.d  = d;
    return v;
  endfunction

  task automatic chk(string nm, logic [1:0] eg, logic [3:0] ec,
                     logic eb, logic [1:0] ed);
    total++;
    if ({grant, count, busy, done} !== {eg, ec, eb, ed}) begin
      bad++;
      $display("FAIL %s: got grant=%b count=%0d busy=%b done=%b, want grant=%b count=%0d busy=%b done=%b",
               nm, grant, count, busy, done, eg, ec, eb, ed);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 2'b00;
    limit = 8'h00;

    // Reset held with both requests up
    @(negedge clk);
    req   = 2'b11;
    limit = 8'h32;
    #1 chk("rst_async", 2'b00, 4'd0, 1'b0, 2'b00);
    edge1();
    chk("rst_hold1", 2'b00, 4'd0, 1'b0, 2'b00);
    edge1();
    chk("rst_hold2", 2'b00, 4'd0, 1'b0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    edge1();
    chk("rst_release", 2'b01, 4'd0, 1'b1, 2'b00);

`ifndef COUNTER_ARB_PRESCALE_EN
    tv[0]  = mk(2'b11, 4'd2, 4'd3, 2'b01, 4'd0, 1'b1, 2'b00);
    tv[1]  = mk(2'b11, 4'd2, 4'd3, 2'b01, 4'd1, 1'b1, 2'b00);
    tv[2]  = mk(2'b11, 4'd2, 4'd3, 2'b01, 4'd2, 1'b1, 2'b00);
    tv[3]  = mk(2'b11, 4'd2, 4'd3, 2'b00, 4'd2, 1'b0, 2'b01);
    tv[4]  = mk(2'b11, 4'd2, 4'd3, 2'b00, 4'd2, 1'b0, 2'b00);
    tv[5]  = mk(2'b11, 4'd2, 4'd3, 2'b10, 4'd0, 1'b1, 2'b00);
    tv[6]  = mk(2'b11, 4'd2, 4'd3, 2'b10, 4'd1, 1'b1, 2'b00);
    tv[7]  = mk(2'b11, 4'd2, 4'd3, 2'b10, 4'd2, 1'b1, 2'b00);
    tv[8]  = mk(2'b11, 4'd2, 4'd3, 2'b10, 4'd3, 1'b1, 2'b00);
    tv[9]  = mk(2'b11, 4'd2, 4'd3, 2'b00, 4'd3, 1'b0, 2'b10);
    tv[10] = mk(2'b11, 4'd2, 4'd3, 2'b00, 4'd3, 1'b0, 2'b00);
    tv[11] = mk(2'b11, 4'd2, 4'd3, 2'b01, 4'd0, 1'b1, 2'b00);
    tv[12] = mk(2'b11, 4'd2, 4'd3, 2'b01, 4'd1, 1'b1, 2'b00);
    tv[13] = mk(2'b11, 4'd2, 4'd3, 2'b01, 4'd2, 1'b1, 2'b00);
    tv[14] = mk(2'b11, 4'd2, 4'd3, 2'b00, 4'd2, 1'b0, 2'b01);
    tv[15] = mk(2'b11, 4'd2, 4'd3, 2'b00, 4'd2, 1'b0, 2'b00);
    tv[16] = mk(2'b11, 4'd2, 4'd3, 2'b10, 4'd0, 1'b1, 2'b00);
    tv[17] = mk(2'b00, 4'd2, 4'd3, 2'b00, 4'd0, 1'b0, 2'b00);
    tv[18] = mk(2'b01, 4'd5, 4'd3, 2'b01, 4'd0, 1'b1, 2'b00);
    tv[19] = mk(2'b01, 4'd5, 4'd3, 2'b01, 4'd1, 1'b1, 2'b00);
    tv[20] = mk(2'b01, 4'd5, 4'd3, 2'b01, 4'd2, 1'b1, 2'b00);
    tv[21] = mk(2'b01, 4'd5, 4'd3, 2'b01, 4'd3, 1'b1, 2'b00);
    tv[22] = mk(2'b01, 4'd5, 4'd3, 2'b01, 4'd4, 1'b1, 2'b00);
    tv[23] = mk(2'b01, 4'd5, 4'd3, 2'b01, 4'd5, 1'b1, 2'b00);
    tv[24] = mk(2'b01, 4'd5, 4'd3, 2'b00, 4'd5, 1'b0, 2'b01);
    tv[25] = mk(2'b00, 4'd5, 4'd3, 2'b00, 4'd5, 1'b0, 2'b00);
    tv[26] = mk(2'b10, 4'd5, 4'd0, 2'b10, 4'd0, 1'b1, 2'b00);
    tv[27] = mk(2'b10, 4'd5, 4'd0, 2'b00, 4'd0, 1'b0, 2'b10);
    tv[28] = mk(2'b00, 4'd5, 4'd0, 2'b00, 4'd0, 1'b0, 2'b00);
    tv[29] = mk(2'b01, 4'd1, 4'd0, 2'b01, 4'd0, 1'b1, 2'b00);
    tv[30] = mk(2'b01, 4'd9, 4'd0, 2'b01, 4'd1, 1'b1, 2'b00);
    tv[31] = mk(2'b01, 4'd9, 4'd0, 2'b00, 4'd1, 1'b0, 2'b01);
    tv[32] = mk(2'b00, 4'd9, 4'd0, 2'b00, 4'd1, 1'b0, 2'b00);

    do_reset();
    for (int i = 0; i < 33; i++) begin
      req   = tv[i].r;
      limit = {tv[i].l1, tv[i].l0};
      edge1();
      chk($sformatf("vec%0d", i), tv[i].g, tv[i].c, tv[i].b, tv[i].d);
    end

    // Withdrawal at count 3 hands over to the waiting requester
    do_reset();
    req   = 2'b11;
    limit = {4'd2, 4'd7};
    edge1();
    chk("wd_grant", 2'b01, 4'd0, 1'b1, 2'b00);
    edge1();
    edge1();
    edge1();
    chk("wd_cnt3", 2'b01, 4'd3, 1'b1, 2'b00);
    req = 2'b10;
    edge1();
    chk("wd_drop", 2'b00, 4'd0, 1'b0, 2'b00);
    edge1();
    chk("wd_next", 2'b10, 4'd0, 1'b1, 2'b00);
    edge1();
    chk("wd_next_cnt", 2'b10, 4'd1, 1'b1, 2'b00);

    // Asynchronous reset in the middle of an interval
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 2'b00, 4'd0, 1'b0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-scale limit counts to 15 without wrapping
    do_reset();
    req   = 2'b01;
    limit = {4'd0, 4'd15};
    edge1();
    chk("max_grant", 2'b01, 4'd0, 1'b1, 2'b00);
    for (int k = 1; k <= 15; k++) begin
      edge1();
      chk($sformatf("max_cnt%0d", k), 2'b01, 4'(k), 1'b1, 2'b00);
    end
    edge1();
    chk("max_done", 2'b00, 4'd15, 1'b0, 2'b01);
    req = 2'b00;
    edge1();
    chk("max_idle", 2'b00, 4'd15, 1'b0, 2'b00);
`else
    // Prescaled interval: limit 2, four clocks per step
    do_reset();
    req   = 2'b01;
    limit = {4'd0, 4'd2};
    edge1();
    chk("pre_grant", 2'b01, 4'd0, 1'b1, 2'b00);
    for (int k = 1; k < 12; k++) begin
      edge1();
      chk($sformatf("pre_k%0d", k), 2'b01, 4'(k / 4), 1'b1, 2'b00);
    end
    edge1();
    chk("pre_done", 2'b00, 4'd2, 1'b0, 2'b01);
    req = 2'b00;
    edge1();
    chk("pre_idle", 2'b00, 4'd2, 1'b0, 2'b00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
